stopwatch_core: RTL

//  MM:SS BCD stopwatch/timer core, directly downstream of the clock divider.

---
 rtl/stopwatch_pkg.sv | 7 +
 rtl/stopwatch_if.sv | 20 ++
 rtl/stopwatch_bcd_digit.sv | 23 ++
 rtl/stopwatch_core.sv | 89 ++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared widths, digit limits and FSM state encoding for the MM:SS stopwatch.
package stopwatch_pkg;
    localparam int BCD_W = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX = 9;
    typedef enum logic [1:0] {ST_STOP = 2'd0, ST_RUN = 2'd1, ST_ADJ = 2'd2} state_t;
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: control inputs and display-side outputs of the stopwatch core.
interface stopwatch_if;
    import stopwatch_pkg::*;
    logic             tick;
    logic             start_stop;
    logic             clear;
    logic             adj;
    logic             adj_sel;
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_ones;
    logic             running;
    logic             wrap;
    logic [3:0]       blank;
    modport master (output tick, start_stop, clear, adj, adj_sel,
                    input min_tens, min_ones, sec_tens, sec_ones, running, wrap, blank);
    modport slave  (input tick, start_stop, clear, adj, adj_sel,
                    output min_tens, min_ones, sec_tens, sec_ones, running, wrap, blank);
endinterface

// File: rtl/stopwatch_bcd_digit.sv
// bcd_digit: one registered BCD digit counting 0..MAX; carry flags the MAX->0 step.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = DIGIT_MAX
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);
    localparam logic [BCD_W-1:0] MAX_V = BCD_W'(MAX);
    logic [BCD_W-1:0] q_d, q_q;
    assign carry = inc && (q_q == MAX_V);
    assign q     = q_q;
    always_comb q_d = (clr || carry) ? '0 : inc ? q_q + BCD_W'(1) : q_q;
    always_ff @(posedge clk_in) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch with run/stop, clear and per-field adjust.
// Optional STOPWATCH_BLINK_EN blinks the field being adjusted via the blank mask.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5
) (
    input logic        clk_in,
    input logic        rst,
    stopwatch_if.slave bus
);
    state_t           state_q, state_d;
    logic             tick_q, tick_rise;
    logic             running_q, running_d, wrap_q, wrap_d;
    logic             run, in_adj;
    logic             so_inc, st_inc, mo_inc, mt_inc;
    logic             so_c, st_c, mo_c, mt_c;
    logic [BCD_W-1:0] so_q, st_q, mo_q, mt_q;

    assign tick_rise = bus.tick & ~tick_q;
    assign run       = (state_q == ST_RUN);
    assign in_adj    = (state_q == ST_ADJ);

    // Adjust mode only feeds the selected field and never carries across fields.
    always_comb begin
        state_d   = in_adj ? (bus.adj ? ST_ADJ : ST_STOP)
                  : bus.adj ? ST_ADJ
                  : bus.start_stop ? (run ? ST_STOP : ST_RUN)
                  : state_q;
        running_d = (state_d == ST_RUN);
        so_inc    = tick_rise & (run | (in_adj & ~bus.adj_sel));
        st_inc    = so_c;
        mo_inc    = run ? st_c : (tick_rise & in_adj & bus.adj_sel);
        mt_inc    = mo_c;
        wrap_d    = run & mt_c & ~bus.clear;
    end

    bcd_digit #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk_in(clk_in), .rst(rst), .clr(bus.clear), .inc(so_inc), .q(so_q), .carry(so_c));
    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk_in(clk_in), .rst(rst), .clr(bus.clear), .inc(st_inc), .q(st_q), .carry(st_c));
    bcd_digit #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk_in(clk_in), .rst(rst), .clr(bus.clear), .inc(mo_inc), .q(mo_q), .carry(mo_c));
    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk_in(clk_in), .rst(rst), .clr(bus.clear), .inc(mt_inc), .q(mt_q), .carry(mt_c));

    // tick_q resets high so a divider already high out of reset is not seen as an edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_q    <= 1'b1;
            state_q   <= ST_STOP;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            tick_q    <= bus.tick;
            state_q   <= state_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bus.sec_ones = so_q;
    assign bus.sec_tens = st_q;
    assign bus.min_ones = mo_q;
    assign bus.min_tens = mt_q;
    assign bus.running  = running_q;
    assign bus.wrap     = wrap_q;

`ifdef STOPWATCH_BLINK_EN
    logic       blink_q, blink_d;
    logic [3:0] blank_q, blank_d;
    always_comb begin
        blink_d = (state_d == ST_ADJ && !in_adj) ? 1'b0 : (in_adj && tick_rise) ? ~blink_q : blink_q;
        blank_d = (blink_d && state_d == ST_ADJ) ? (bus.adj_sel ? 4'b1100 : 4'b0011) : 4'b0000;
    end
    always_ff @(posedge clk_in) begin
        if (rst) begin
            blink_q <= 1'b0;
            blank_q <= 4'b0000;
        end else begin
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end
    assign bus.blank = blank_q;
`else
    assign bus.blank = 4'b0000;
`endif
endmodule
